// File: rtl/flash_tcm_pkg.sv
// Shared types and timing defaults for the CFI flash tri-state conduit controller.
package flash_tcm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_TURN  = 3'd4
   } tcm_state_t;

   localparam int DEF_ADDR_W       = 22;
   localparam int DEF_DATA_W       = 8;
   localparam int DEF_SETUP_CYCLES = 2;
   localparam int DEF_WAIT_CYCLES  = 7;
   localparam int DEF_HOLD_CYCLES  = 2;
   localparam int DEF_TURN_CYCLES  = 2;

   // Bits needed to hold the largest phase length; never below one bit.
   function automatic int cnt_width(input int s, input int w, input int h, input int t);
      int m;
      m = s;
      if (w > m) m = w;
      if (h > m) m = h;
      if (t > m) m = t;
      return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/flash_tcm_phase_counter.sv
// Down-counter that times one bus phase; reloads on load, never wraps below zero.
module flash_tcm_phase_counter
   import flash_tcm_pkg::*;
#(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic          zero
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/flash_tcm_controller.sv
// Avalon-MM slave that sequences single-word CFI flash accesses through
// setup / strobe / hold / turnaround phases on a tri-state conduit.
module flash_tcm_controller
   import flash_tcm_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
   parameter int WAIT_CYCLES  = DEF_WAIT_CYCLES,
   parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int TURN_CYCLES  = DEF_TURN_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [DATA_W-1:0] avs_writedata,
   output logic              avs_waitrequest,
   output logic [DATA_W-1:0] avs_readdata,
   output logic              avs_readdatavalid,
   output logic [ADDR_W-1:0] tcm_address_out,
   output logic              tcm_read_n_out,
   output logic              tcm_write_n_out,
   output logic              tcm_chipselect_n_out,
   output logic [DATA_W-1:0] tcm_data_out,
   output logic              tcm_data_outen,
   input  logic [DATA_W-1:0] tcm_data_in
);

   localparam int CW   = cnt_width(SETUP_CYCLES, WAIT_CYCLES, HOLD_CYCLES, TURN_CYCLES);
   localparam int T_LD = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;

   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] WAIT_LD  = CW'(WAIT_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] TURN_LD  = CW'(T_LD);

   tcm_state_t    state, state_nxt;
   logic          is_read, rd_nxt;
   logic          accept;
   logic          cnt_load, cnt_zero, cnt_dec;
   logic [CW-1:0] cnt_load_val;
   logic          bus_nxt;

   flash_tcm_phase_counter #(.CW(CW)) u_phase_cnt (
      .clk      (clk),
      .rst      (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   assign cnt_dec = (state != ST_IDLE);

   always_comb begin
      state_nxt    = state;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      accept       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (avs_read || avs_write) begin
               state_nxt    = ST_SETUP;
               cnt_load     = 1'b1;
               cnt_load_val = SETUP_LD;
               accept       = 1'b1;
            end
         end
         ST_SETUP: begin
            if (cnt_zero) begin
               state_nxt    = ST_WAIT;
               cnt_load     = 1'b1;
               cnt_load_val = WAIT_LD;
            end
         end
         ST_WAIT: begin
            if (cnt_zero) begin
               state_nxt    = ST_HOLD;
               cnt_load     = 1'b1;
               cnt_load_val = HOLD_LD;
            end
         end
         ST_HOLD: begin
            if (cnt_zero) begin
               if (is_read && (TURN_CYCLES > 0)) begin
                  state_nxt    = ST_TURN;
                  cnt_load     = 1'b1;
                  cnt_load_val = TURN_LD;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_TURN: begin
            if (cnt_zero) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // A simultaneous read and write is treated as a read.
   assign rd_nxt  = accept ? avs_read : is_read;
   assign bus_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_WAIT) || (state_nxt == ST_HOLD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         is_read <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) is_read <= avs_read;
      end
   end

   // Pin outputs are registered from the next-state decode so they line up with the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tcm_chipselect_n_out <= 1'b1;
         tcm_read_n_out       <= 1'b1;
         tcm_write_n_out      <= 1'b1;
         tcm_data_outen       <= 1'b0;
         tcm_address_out      <= '0;
         tcm_data_out         <= '0;
         avs_readdata         <= '0;
         avs_readdatavalid    <= 1'b0;
      end else begin
         tcm_chipselect_n_out <= !bus_nxt;
         tcm_read_n_out       <= !((state_nxt == ST_WAIT) && rd_nxt);
         tcm_write_n_out      <= !((state_nxt == ST_WAIT) && !rd_nxt);
         tcm_data_outen       <= bus_nxt && !rd_nxt;
         if (accept) begin
            tcm_address_out <= avs_address;
            tcm_data_out    <= avs_writedata;
         end
         avs_readdatavalid <= (state == ST_WAIT) && cnt_zero && is_read;
         if ((state == ST_WAIT) && cnt_zero && is_read)
            avs_readdata <= tcm_data_in;
      end
   end

   assign avs_waitrequest = reset || (state != ST_IDLE);

endmodule

// File: doc/flash_tcm_controller.md
# flash_tcm_controller

Avalon-MM slave that turns single-word read/write requests into timed CFI flash tri-state conduit (TCM) cycles. It drives the address, read_n, write_n, chipselect_n and split data lines that the conduit pin divider merges onto the shared flash pins. Bus timing is set by per-phase cycle counts: setup, wait (strobe), hold and bus turnaround. One transaction is in flight at a time.

## Interface
- ADDR_W, 22, flash word address width
- DATA_W, 8, flash data width
- SETUP_CYCLES, 2, cycles with chip select and address valid before the strobe; legal range ≥1
- WAIT_CYCLES, 7, cycles with read_n or write_n low; legal range ≥1
- HOLD_CYCLES, 2, cycles with chip select and address held after the strobe; legal range ≥1
- TURN_CYCLES, 2, idle cycles with chip select high after a read, before the next access; 0 is legal and skips the phase

- clk  in  1  single clock; all state is on its rising edge
- reset  in  1  asynchronous, active-high
- avs_address  in  ADDR_W  request address
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_writedata  in  DATA_W  write data
- avs_waitrequest  out  1  high while busy or in reset
- avs_readdata  out  DATA_W  registered read data
- avs_readdatavalid  out  1  one-cycle pulse, qualifies avs_readdata
- tcm_address_out  out  ADDR_W  flash address
- tcm_read_n_out  out  1  output enable, active low
- tcm_write_n_out  out  1  write enable, active low
- tcm_chipselect_n_out  out  1  chip select, active low
- tcm_data_out  out  DATA_W  write data toward the pin
- tcm_data_outen  out  1  drives tcm_data_out onto the pin when high
- tcm_data_in  in  DATA_W  data sampled from the pin

## Operation
- **States:** IDLE, SETUP, WAIT, HOLD, TURN.
- **avs_waitrequest** = reset OR (state ≠ IDLE). It is combinational from the state register.
- **IDLE:** a request is accepted on the edge where avs_read or avs_write is high.
  - The controller latches address, the read/write flag and the write data.
  - It goes to SETUP and loads the phase counter with SETUP_CYCLES-1.
  - If avs_read and avs_write are both high, it performs the read and ignores the write.
- **Phase counter:** counts down each cycle. When it reaches 0 the state advances to the next phase and the counter reloads with that phase's count minus 1.
  - Sequence: SETUP → WAIT → HOLD.
  - HOLD then goes to TURN after a read with TURN_CYCLES > 0, otherwise to IDLE.
  - TURN goes to IDLE.
- **Chip select:** tcm_chipselect_n_out is low in SETUP, WAIT and HOLD, and high in IDLE and TURN.
- **Address:** tcm_address_out holds the latched address from SETUP through HOLD. It keeps its last value otherwise.
- **Strobe:** tcm_read_n_out (read) or tcm_write_n_out (write) is low only in WAIT.
- **Write data:** tcm_data_outen is high in SETUP, WAIT and HOLD of a write, and low at all other times. tcm_data_out holds the latched write data.
- **Read capture:** tcm_data_in is registered into avs_readdata on the edge that ends the last WAIT cycle. avs_readdatavalid is high for exactly the first HOLD cycle.
- **Widths:** the counter is $clog2(max(SETUP,WAIT,HOLD,TURN)+1) bits wide. It does not wrap; it only reloads.
- **Reset (asynchronous, including mid-transaction):**
  - Outputs go immediately to: chipselect_n=1, read_n=1, write_n=1, outen=0, address=0, data_out=0, readdata=0, readdatavalid=0. State goes to IDLE.
  - An in-flight read produces no readdatavalid.
  - On reset release the controller is in IDLE with waitrequest=0.

## Timing
Cycle 0 is the accept edge. S=SETUP_CYCLES, W=WAIT_CYCLES, H=HOLD_CYCLES, T=TURN_CYCLES.
- **SETUP:** cycles 1..S.
- **WAIT:** cycles S+1..S+W.
- **HOLD:** cycles S+W+1..S+W+H.
- **Read data:** readdatavalid at cycle S+W+1.
- **Next accept, write:** possible at cycle S+W+H+1.
- **Next accept, read:** possible at cycle S+W+H+T+1.
- **Back-to-back:** there is no extra gap beyond TURN. A request held through waitrequest is accepted in the first IDLE cycle.

## Structure
- **flash_tcm_pkg** holds:
  - the state enum typedef (tcm_state_t);
  - a counter-width helper function;
  - default timing constants.
- **flash_tcm_phase_counter:** a small sub-module with load, load value, decrement and zero flag. It is instantiated once.
- All data and control outputs are registered. avs_waitrequest is the only output decoded from state.

## Test plan
- **Read, defaults:** read at 0x12345 with tcm_data_in=0xA5 →
  - chipselect_n low cycles 1–11, read_n low cycles 3–9;
  - readdatavalid with 0xA5 at cycle 10;
  - TURN at cycles 12–13; waitrequest low again at cycle 14.
- **Write, defaults:** write 0x3C to 0x00010 →
  - outen high cycles 1–11 with data_out=0x3C;
  - write_n low cycles 3–9; read_n stays high;
  - no readdatavalid; IDLE at cycle 12.
- **Back-to-back:** write immediately followed by a held read → read accepted at cycle 12. Read then write → write accepted at cycle 14.
- **Read and write together:** avs_read and avs_write both high → read cycle only; write_n never low.
- **Reset mid-operation:** reset asserted at cycle 5 of a read → within that cycle chipselect_n=1, read_n=1, outen=0; no readdatavalid follows.
- **Zero turnaround:** TURN_CYCLES=0, SETUP=1, WAIT=1, HOLD=1 → read readdatavalid at cycle 3; next accept at cycle 4.
